// File: rtl/ucq_dedup_fifo_pkg.sv
// Shared literal types for the unit-clause path.
package ucq_dedup_fifo_pkg;

  localparam int LIT_W       = 16;
  localparam int LIT_IDX_MAX = (1 << (LIT_W - 1)) - 1;

  // Sign gives polarity; zero is the null literal.
  typedef logic signed [LIT_W-1:0] lit_t;

endpackage

// File: rtl/ucq_dedup_fifo_if.sv
// Producer/consumer bundle of the unit-clause queue; slave side is the queue itself.
interface ucq_dedup_fifo_if
  import ucq_dedup_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
);

  logic             flush;
  logic             push;
  lit_t             push_lit;
  logic             full;
  logic             pop;
  lit_t             pop_lit;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             dup_drop;
  logic             conflict;

  modport master (
    output flush, push, push_lit, pop,
    input  full, pop_lit, empty, count, dup_drop, conflict
  );

  modport slave (
    input  flush, push, push_lit, pop,
    output full, pop_lit, empty, count, dup_drop, conflict
  );

endinterface

// File: rtl/ucq_dedup_fifo_lit_match_cam.sv
// Compares one literal, and its negation, against a masked set of held literals.
module ucq_dedup_fifo_lit_match_cam
  import ucq_dedup_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  lit_t             lit_i,
  input  lit_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  output logic             eq_hit_o,
  output logic             neg_hit_o
);

  lit_t neg_lit;

  // |lit| never reaches the most-negative code, so negation cannot overflow.
  assign neg_lit = -lit_i;

  always_comb begin
    eq_hit_o  = 1'b0;
    neg_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (entries_i[i] == lit_i))   eq_hit_o  = 1'b1;
      if (valid_i[i] && (entries_i[i] == neg_lit)) neg_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/ucq_dedup_fifo.sv
// First-word-fall-through literal queue that drops duplicates and flags x / -x conflicts.
module ucq_dedup_fifo
  import ucq_dedup_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  ucq_dedup_fifo_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);

  lit_t             mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q,    vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             dup_q,    dup_d;
  logic             conf_q,   conf_d;

  logic             full_w;
  logic             pop_acc;
  logic             push_live;
  logic             push_ok;
  logic             eq_hit;
  logic             neg_hit;
  logic [DEPTH-1:0] match_mask;

  // The departing head must not block its own negation in the same cycle.
  always_comb begin
    full_w     = (cnt_q == CNT_W'(DEPTH));
    pop_acc    = q.pop && (cnt_q != '0);
    match_mask = vld_q;
    if (pop_acc) match_mask[rd_ptr_q] = 1'b0;
  end

  ucq_dedup_fifo_lit_match_cam #(.DEPTH(DEPTH)) u_cam (
    .lit_i     (q.push_lit),
    .entries_i (mem_q),
    .valid_i   (match_mask),
    .eq_hit_o  (eq_hit),
    .neg_hit_o (neg_hit)
  );

  always_comb begin
    push_live = q.push && !conf_q && (q.push_lit != '0);
    push_ok   = push_live && !eq_hit && !neg_hit && (!full_w || pop_acc);
    dup_d     = push_live && eq_hit;
    conf_d    = conf_q || (push_live && !eq_hit && neg_hit);

    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // Clear before set: when full, push and pop hit the same slot.
    if (pop_acc) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      dup_q    <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      dup_q    <= dup_d;
      conf_q   <= conf_d;
    end
  end

  // Payload needs no reset; the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= q.push_lit;
  end

  assign q.pop_lit  = vld_q[rd_ptr_q] ? mem_q[rd_ptr_q] : '0;
  assign q.empty    = (cnt_q == '0);
  assign q.full     = full_w;
  assign q.count    = cnt_q;
  assign q.dup_drop = dup_q;
  assign q.conflict = conf_q;

endmodule

// File: tb/tb_ucq_dedup_fifo.sv
// Directed and randomized checks of ucq_dedup_fifo against a queue-based model.
module tb_ucq_dedup_fifo;
  import ucq_dedup_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ucq_dedup_fifo_if #(.DEPTH(DEPTH)) bus ();
  ucq_dedup_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

  int n_tests = 0;
  int n_fail  = 0;

  int mq[$];
  bit m_conf = 1'b0;
  bit m_dup  = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model of one clock edge, written from the queue's rules.
  task automatic model_edge(input bit r, input bit f, input bit p, input int lit, input bit po);
    bit pop_acc, hit_eq, hit_neg, take;
    if (r || f) begin
      mq.delete();
      m_conf = 1'b0;
      m_dup  = 1'b0;
      return;
    end
    pop_acc = po && (mq.size() > 0);
    hit_eq = 1'b0; hit_neg = 1'b0; take = 1'b0;
    for (int i = (pop_acc ? 1 : 0); i < mq.size(); i++) begin
      if (mq[i] == lit)  hit_eq  = 1'b1;
      if (mq[i] == -lit) hit_neg = 1'b1;
    end
    m_dup = 1'b0;
    if (p && !m_conf && lit != 0) begin
      if (hit_eq)                                  m_dup  = 1'b1;
      else if (hit_neg)                            m_conf = 1'b1;
      else if (mq.size() < DEPTH || pop_acc)       take   = 1'b1;
    end
    if (pop_acc) void'(mq.pop_front());
    if (take) mq.push_back(lit);
  endtask

  task automatic compare_all();
    check("count",    int'(bus.count),            mq.size());
    check("empty",    int'(bus.empty),            int'(mq.size() == 0));
    check("full",     int'(bus.full),             int'(mq.size() == DEPTH));
    check("pop_lit",  int'($signed(bus.pop_lit)), (mq.size() > 0) ? mq[0] : 0);
    check("dup_drop", int'(bus.dup_drop),         int'(m_dup));
    check("conflict", int'(bus.conflict),         int'(m_conf));
  endtask

  task automatic step(input bit r, input bit f, input bit p, input int lit, input bit po);
    rst          = r;
    bus.flush    = f;
    bus.push     = p;
    bus.push_lit = lit_t'(lit);
    bus.pop      = po;
    @(posedge clk);
    model_edge(r, f, p, lit, po);
    #1;
    compare_all();
  endtask

  task automatic idle();     step(0, 0, 0, 0, 0); endtask
  task automatic push(int l); step(0, 0, 1, l, 0); endtask
  task automatic pop1();     step(0, 0, 0, 0, 1); endtask
  task automatic flush();    step(0, 1, 0, 0, 0); endtask

  initial begin
    int lit, sgn;
    bit wide;
    rst = 1'b1; bus.flush = 1'b0; bus.push = 1'b0; bus.push_lit = '0; bus.pop = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 5, 1);
    check("reset_count", int'(bus.count), 0);

    // In-order delivery
    push(3); check("first_head", int'($signed(bus.pop_lit)), 3);
    push(5); push(-7);
    check("three_count", int'(bus.count), 3);
    pop1(); check("head_after_pop", int'($signed(bus.pop_lit)), 5);
    pop1(); pop1();
    check("drained_empty", int'(bus.empty), 1);

    // Duplicate suppression
    flush(); push(4); push(4);
    check("dup_pulse", int'(bus.dup_drop), 1);
    idle();
    check("dup_one_cycle", int'(bus.dup_drop), 0);
    check("dup_count", int'(bus.count), 1);

    // Conflict is sticky and blocks further pushes
    flush(); push(9); push(-9);
    check("conflict_set", int'(bus.conflict), 1);
    push(2); idle();
    check("conflict_sticky", int'(bus.conflict), 1);
    check("conflict_count", int'(bus.count), 1);
    flush();
    check("flush_conflict", int'(bus.conflict), 0);
    check("flush_count", int'(bus.count), 0);

    // Fill, overflow, push+pop at full, drain across the wrap
    flush();
    for (int i = 1; i <= DEPTH; i++) push(i);
    check("fill_full", int'(bus.full), 1);
    push(17);
    check("overflow_count", int'(bus.count), DEPTH);
    step(0, 0, 1, 17, 1);
    check("full_pushpop_full", int'(bus.full), 1);
    for (int i = 2; i <= 17; i++) begin
      check("drain_order", int'($signed(bus.pop_lit)), i);
      pop1();
    end
    check("drain_empty", int'(bus.empty), 1);

    // Leaving head is excluded from the match set
    flush(); push(6);
    step(0, 0, 1, -6, 1);
    check("head_excl_conflict", int'(bus.conflict), 0);
    check("head_excl_lit", int'($signed(bus.pop_lit)), -6);

    // Push+pop on empty: push lands, pop ignored
    flush();
    step(0, 0, 1, 8, 1);
    check("empty_pushpop", int'(bus.count), 1);

    // Reset mid-stream, then a null push
    flush();
    for (int i = 1; i <= 5; i++) push(i * 2);
    step(0, 0, 1, 11, 1);
    step(1, 0, 1, 13, 1);
    check("rst_mid_count", int'(bus.count), 0);
    push(0);
    check("null_push", int'(bus.count), 0);

    // Randomized traffic: alternating narrow (dup/conflict rich) and wide (fill-heavy) phases
    for (int c = 0; c < 4000; c++) begin
      wide = ((c / 400) % 2) == 1;
      sgn  = ($urandom_range(0, 1) == 1) ? -1 : 1;
      lit  = wide ? sgn * int'($urandom_range(1, 60)) : int'($urandom_range(0, 12)) - 6;
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, wide ? 199 : 39) == 0,
           $urandom_range(0, 9) < 7,
           lit,
           $urandom_range(0, 9) < (wide ? 2 : 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucq_dedup_fifo.md
Name: ucq_dedup_fifo

Overview:
- Unit-clause queue between the propagation engine and the unit-clause arbiter. Two instances per engine: UCQ_in (engine → arbiter) and UCQ_out (arbiter → engine).
- First-word-fall-through FIFO of signed literals.
- On each push, searches all held entries. Duplicate literals are suppressed. A literal whose negation is already queued raises a sticky conflict.
- Keeps redundant unit clauses out of the arbiter and detects x / ¬x conflicts one cycle after the push.

Parameters:
- DEPTH, 16, number of literal entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  clear all entries and the conflict flag; same effect as rst.
- push  input  1  request to enqueue push_lit.
- push_lit  input  lit_t  literal to enqueue; sign gives polarity; 0 is a null literal.
- full  output  1  count == DEPTH.
- pop  input  1  dequeue the head entry.
- pop_lit  output  lit_t  head literal; valid when !empty.
- empty  output  1  count == 0.
- count  output  CNT_W  number of entries held.
- dup_drop  output  1  one-cycle pulse: the previous cycle's push was a duplicate and was dropped.
- conflict  output  1  sticky: a literal and its negation met in the queue.

Behaviour:
- Reset and flush values:
  - rst and flush are both synchronous and take effect at the clock edge.
  - rst has priority over flush; flush has priority over push and pop in the same cycle.
  - After either: count=0, empty=1, full=0, pop_lit=0, dup_drop=0, conflict=0, both pointers=0, all valid bits cleared.
- Storage: circular buffer with a valid bit per entry. rd_ptr and wr_ptr wrap modulo DEPTH.
- Pop:
  - Accepted when pop && !empty.
  - The head is invalidated and rd_ptr advances.
  - Pop while empty is ignored with no side effects.
- Push match set:
  - Entries valid at the start of the cycle, excluding the head if a pop is accepted in the same cycle.
- Push decision, evaluated in priority order:
  1. conflict already set → push ignored.
  2. push_lit == 0 → ignored.
  3. Any entry in the match set equals push_lit → dropped; dup_drop=1 next cycle.
  4. Any entry in the match set equals -push_lit → dropped; conflict=1 next cycle.
  5. full && !(pop accepted) → ignored (overflow is the producer's fault; no flag).
  6. Otherwise → written at wr_ptr, wr_ptr advances.
- Simultaneous push and pop when full: both accepted; count stays DEPTH.
- Simultaneous push and pop when empty: the pop is ignored and the push is accepted (no bypass). pop_lit shows the literal the following cycle.
- Latency:
  - A pushed literal appears on pop_lit/!empty one cycle after the push edge.
  - count, full and empty are registered-derived and update at the same edge.
- Arithmetic:
  - Negation is two's-complement on the full lit_t width.
  - The most-negative encoding is never produced, since |lit| ≤ LIT_IDX_MAX.
  - count is incremented by the push, decremented by the pop; net 0 when both are accepted.
- conflict: holds until rst or flush. Pops remain legal after conflict so the consumer can drain.
- dup_drop: high for exactly one cycle per dropped duplicate.

Decomposition:
- Shared package (existing): lit_t and LIT_IDX_MAX. No new typedefs are needed.
- One natural sub-module: lit_match_cam.
  - Combinational compare of one literal against DEPTH entries under a valid mask.
  - Outputs: eq_hit and neg_hit.
  - Reused later by the arbiter's assignment check.

Test Plan:
- Push 3, 5, -7 on consecutive cycles, then pop ×3 → pop_lit sequence 3, 5, -7; count 1,2,3,2,1,0; empty at the end.
- Push 4, then push 4 → second push dropped; dup_drop=1 for exactly one cycle; count=1.
- Push 9, then push -9 → conflict=1 on the next cycle and stays high; count=1; a subsequent push of 2 is ignored; flush clears conflict and count to 0.
- Fill to DEPTH=16 with literals 1..16, then push 17 alone → ignored, count=16. Push 17 together with a pop → head 1 leaves, 17 is accepted, count=16, full stays 1. Drain → 2..17 in order, including pointer wrap.
- Queue holds only 6; pop together with push of -6 → head excluded from the match set; -6 is enqueued with no conflict; pop_lit=-6 next cycle.
- Assert rst during a mixed push/pop stream with count=5, then push 0 after reset → all outputs return to reset values the cycle after reset; the push of 0 has no effect.
